bin2bcd_iter: RTL and testbench

Parametrised, iterative (one shift-add-3 step per clock) binary-to-packed-BCD converter with a start/done handshake.
Feeds the seven-segment score and timer displays.
Adds three things the game display path needs: configurable input width and digit count, overflow saturation, and a per-digit leading-zero blank mask for the segment driver.
Trades the large combinational adder chain for BIN_W cycles of latency.

---
 rtl/bin2bcd_iter_if.sv | 34 +++
 rtl/bin2bcd_iter.sv | 125 ++++++++++++
 tb/tb_bin2bcd_iter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_iter_if.sv
// rtl/bin2bcd_iter_if.sv - start/done handshake bundle for bin2bcd_iter
//
// Purpose: groups the request side (start, bin) and the result side
// (busy, done, bcd, blank, ovf) of the iterative BCD converter.
// Ports (signals):
//   start  master->slave  conversion request
//   bin    master->slave  BIN_W-bit unsigned value
//   busy   slave->master  conversion in progress
//   done   slave->master  one-cycle result-updated pulse
//   bcd    slave->master  4*DIGITS packed BCD, digit 0 = units
//   blank  slave->master  per-digit leading-zero blank mask
//   ovf    slave->master  value did not fit in DIGITS digits
interface bin2bcd_iter_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic [DIGITS-1:0]     blank;
  logic                  ovf;

  modport master (
    output start, bin,
    input  busy, done, bcd, blank, ovf
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, blank, ovf
  );
endinterface

// File: rtl/bin2bcd_iter.sv
// rtl/bin2bcd_iter.sv - iterative double-dabble binary to packed BCD converter
//
// Purpose: converts an unsigned BIN_W-bit value to DIGITS packed BCD digits,
// one shift-add-3 step per clock, with overflow saturation to all nines and
// a leading-zero blank mask for the seven-segment driver.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  bin2bcd_iter_if.slave (start/bin in; busy/done/bcd/blank/ovf out)
module bin2bcd_iter #(
  parameter int BIN_W    = 16,
  parameter int DIGITS   = 5,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  bin2bcd_iter_if.slave  bus
);

  localparam int CW = $clog2(BIN_W + 1);
  localparam int BW = 4 * DIGITS;
  localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);
  // Idle display shows a single "0": every digit but the units is blanked.
  localparam logic [DIGITS-1:0] BLANK_RST = BLANK_LZ ? ~DIGITS'(1) : '0;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [BIN_W-1:0]  sh_q;
  logic [BW-1:0]     scr_q;
  logic              sov_q;
  logic              busy_q;
  logic              done_q;
  logic [BW-1:0]     bcd_q;
  logic [DIGITS-1:0] blank_q;
  logic              ovf_q;

  logic [BW-1:0]     scr_adj;
  logic [BW-1:0]     scr_d;
  logic [BIN_W-1:0]  sh_d;
  logic              sov_d;
  logic [BW-1:0]     nines;
  logic [BW-1:0]     bcd_d;
  logic [DIGITS-1:0] blank_d;
  logic              zrun;

  always_comb begin
    scr_adj = scr_q;
    nines   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] > 4'd4) begin
        scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
      nines[4*i +: 4] = 4'd9;
    end
    scr_d = {scr_adj[BW-2:0], sh_q[BIN_W-1]};
    sh_d  = sh_q << 1;
    // Anything leaving the top digit means the value cannot fit; sticky.
    sov_d = sov_q | scr_adj[BW-1];
    bcd_d = sov_d ? nines : scr_d;
    // Walk from the most significant digit down; a digit is blanked only
    // while every digit above it (and itself) is zero. Digit 0 never blanks.
    blank_d = '0;
    zrun    = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zrun       = zrun & (scr_d[4*i +: 4] == 4'd0);
      blank_d[i] = BLANK_LZ & ~sov_d & zrun;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      scr_q   <= '0;
      sov_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      blank_q <= BLANK_RST;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        // DONE accepts a new start exactly like IDLE for back-to-back use.
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            sh_q    <= bus.bin;
            scr_q   <= '0;
            sov_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          scr_q <= scr_d;
          sh_q  <= sh_d;
          sov_q <= sov_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            bcd_q   <= bcd_d;
            blank_q <= blank_d;
            ovf_q   <= sov_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.bcd   = bcd_q;
  assign bus.blank = blank_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_bin2bcd_iter.sv
// tb/tb_bin2bcd_iter.sv - scoreboard bench for bin2bcd_iter
//
// Purpose: drives directed conversions into three converter instances
// (defaults; DIGITS=4; BLANK_LZ=0) and checks every done pulse against
// hand-computed expected results queued at stimulus time.
// Ports: none (top-level bench).
module tb_bin2bcd_iter;

  typedef struct {
    logic [19:0] bcd;
    logic [4:0]  blank;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cyc = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bin2bcd_iter_if #(.BIN_W(16), .DIGITS(5)) if0 ();
  bin2bcd_iter_if #(.BIN_W(16), .DIGITS(4)) if1 ();
  bin2bcd_iter_if #(.BIN_W(16), .DIGITS(5)) if2 ();

  bin2bcd_iter #(.BIN_W(16), .DIGITS(5), .BLANK_LZ(1'b1)) u0 (.clk(clk), .rst(rst), .bus(if0));
  bin2bcd_iter #(.BIN_W(16), .DIGITS(4), .BLANK_LZ(1'b1)) u1 (.clk(clk), .rst(rst), .bus(if1));
  bin2bcd_iter #(.BIN_W(16), .DIGITS(5), .BLANK_LZ(1'b0)) u2 (.clk(clk), .rst(rst), .bus(if2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic exp_t mk(input logic [19:0] b, input logic [4:0] bl, input logic o);
    exp_t e;
    e.bcd = b; e.blank = bl; e.ovf = o;
    return e;
  endfunction

  // Monitors: pop and compare on every done pulse.
  always @(negedge clk) begin
    if (!rst && if0.done === 1'b1) begin
      if (q0.size() == 0) check("u0_unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q0.pop_front();
        check("u0_bcd", {12'h0, if0.bcd}, {12'h0, e.bcd});
        check("u0_blank", {27'h0, if0.blank}, {27'h0, e.blank});
        check("u0_ovf", {31'h0, if0.ovf}, {31'h0, e.ovf});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && if1.done === 1'b1) begin
      if (q1.size() == 0) check("u1_unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q1.pop_front();
        check("u1_bcd", {16'h0, if1.bcd}, {12'h0, e.bcd});
        check("u1_blank", {28'h0, if1.blank}, {27'h0, e.blank});
        check("u1_ovf", {31'h0, if1.ovf}, {31'h0, e.ovf});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && if2.done === 1'b1) begin
      if (q2.size() == 0) check("u2_unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q2.pop_front();
        check("u2_bcd", {12'h0, if2.bcd}, {12'h0, e.bcd});
        check("u2_blank", {27'h0, if2.blank}, {27'h0, e.blank});
        check("u2_ovf", {31'h0, if2.ovf}, {31'h0, e.ovf});
      end
    end
  end

  // One conversion on u0; bin is scrambled after acceptance and busy
  // must be seen on exactly 16 sample points before done.
  task automatic run0(input logic [15:0] b, input exp_t e);
    int n;
    bit got;
    @(negedge clk);
    if0.start = 1'b1;
    if0.bin   = b;
    q0.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if0.start = 1'b0;
    if0.bin   = ~b;
    n = 0;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (if0.done === 1'b1) got = 1;
      else begin
        if (if0.busy === 1'b1) n++;
        @(negedge clk);
      end
    end
    check("u0_done_seen", {31'h0, got}, 32'd1);
    check("u0_busy_cycles", n, 16);
    check("u0_busy_in_done", {31'h0, if0.busy}, 32'd0);
  endtask

  task automatic run1(input logic [15:0] b, input exp_t e);
    bit got;
    @(negedge clk);
    if1.start = 1'b1;
    if1.bin   = b;
    q1.push_back(e);
    @(negedge clk);
    if1.start = 1'b0;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (if1.done === 1'b1) got = 1;
      else @(negedge clk);
    end
    check("u1_done_seen", {31'h0, got}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int t[3];
    int got;
    if0.start = 0; if0.bin = 0;
    if1.start = 0; if1.bin = 0;
    if2.start = 0; if2.bin = 0;
    #1 rst = 1'b1;
    #2;
    check("rst_u0_busy", {31'h0, if0.busy}, 0);
    check("rst_u0_done", {31'h0, if0.done}, 0);
    check("rst_u0_bcd", {12'h0, if0.bcd}, 0);
    check("rst_u0_ovf", {31'h0, if0.ovf}, 0);
    check("rst_u0_blank", {27'h0, if0.blank}, 32'b11110);
    check("rst_u1_blank", {28'h0, if1.blank}, 32'b1110);
    check("rst_u2_blank", {27'h0, if2.blank}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run0(16'd65535, mk(20'h65535, 5'b00000, 1'b0));
    run0(16'd0,     mk(20'h00000, 5'b11110, 1'b0));
    run0(16'd1234,  mk(20'h01234, 5'b10000, 1'b0));
    // Outputs hold between conversions.
    repeat (3) @(negedge clk);
    check("u0_hold_bcd", {12'h0, if0.bcd}, 32'h01234);

    run1(16'd12345, mk(20'h09999, 5'b00000, 1'b1));
    run1(16'd9999,  mk(20'h09999, 5'b00000, 1'b0));
    run1(16'd10000, mk(20'h09999, 5'b00000, 1'b1));

    // Start re-pulsed with 42 at E0+5 while converting 500: ignored.
    @(negedge clk);
    if0.start = 1'b1; if0.bin = 16'd500;
    q0.push_back(mk(20'h00500, 5'b11000, 1'b0));
    @(posedge clk);
    @(negedge clk);
    if0.start = 1'b0;
    repeat (4) @(negedge clk);
    if0.start = 1'b1; if0.bin = 16'd42;
    @(negedge clk);
    if0.start = 1'b0;
    repeat (30) @(negedge clk);
    check("u0_q_after_repulse", q0.size(), 0);

    // Reset asserted mid-conversion aborts it with no done pulse.
    @(negedge clk);
    if0.start = 1'b1; if0.bin = 16'd300;
    @(posedge clk);
    @(negedge clk);
    if0.start = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", {31'h0, if0.busy}, 0);
    check("abort_bcd", {12'h0, if0.bcd}, 0);
    check("abort_done", {31'h0, if0.done}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    run0(16'd99, mk(20'h00099, 5'b11100, 1'b0));

    // Start held high on the BLANK_LZ=0 instance: back-to-back every 17.
    @(negedge clk);
    if2.start = 1'b1; if2.bin = 16'd7;
    for (int k = 0; k < 3; k++) q2.push_back(mk(20'h00007, 5'b00000, 1'b0));
    got = 0;
    for (int k = 0; k < 100 && got < 3; k++) begin
      @(negedge clk);
      if (if2.done === 1'b1) begin
        t[got] = cyc;
        got++;
        if (got == 3) if2.start = 1'b0;
      end
    end
    check("u2_done_count", got, 3);
    check("u2_period_a", t[1] - t[0], 17);
    check("u2_period_b", t[2] - t[1], 17);

    repeat (25) @(negedge clk);
    check("q0_empty", q0.size(), 0);
    check("q1_empty", q1.size(), 0);
    check("q2_empty", q2.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
